// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the obstacle game datapath.
//   - run_state_t    : 2-bit FSM state encoding (IDLE/RUN/PAUSED/OVER)
//   - ALL_BLOCKED    : lane mask with every lane blocked
//   - OPEN_SUB       : replacement mask that always leaves a lane open
//   - clamp_lane()   : maps the 2-bit player lane onto the 3 real lanes
//   - lane_mask()    : converts a raw LFSR state into an obstacle row
// ---------------------------------------------------------------------------
package game_pkg;

  typedef logic [1:0] run_state_t;

  localparam run_state_t ST_IDLE   = 2'd0;
  localparam run_state_t ST_RUN    = 2'd1;
  localparam run_state_t ST_PAUSED = 2'd2;
  localparam run_state_t ST_OVER   = 2'd3;

  localparam logic [2:0] ALL_BLOCKED = 3'b111;
  localparam logic [2:0] OPEN_SUB    = 3'b101;

  // Lane code 3 does not exist on screen; treat it as the rightmost lane.
  function automatic logic [1:0] clamp_lane(input logic [1:0] lane);
    return (lane == 2'd3) ? 2'd2 : lane;
  endfunction

  // A fully blocked row would be unwinnable, so substitute one with a gap.
  function automatic logic [2:0] lane_mask(input logic [2:0] s);
    return (s == ALL_BLOCKED) ? OPEN_SUB : s;
  endfunction

endpackage

// File: rtl/row_shift_buffer.sv
// ---------------------------------------------------------------------------
// row_shift_buffer
//   DEPTH x LANES obstacle shift register. Row 0 is the newest (top) row,
//   row DEPTH-1 is the player row.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     clear        : synchronous clear of every row (has priority over load)
//     load         : shift all rows down by one and load din into row 0
//     din          : new row 0 contents
//     rows_flat    : all rows, row i at bits [i*LANES +: LANES]
//     bottom_row   : current contents of row DEPTH-1
//     bottom_next  : value row DEPTH-1 takes if load is applied this cycle
// ---------------------------------------------------------------------------
module row_shift_buffer #(
  parameter int DEPTH = 4,
  parameter int LANES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load,
  input  logic [LANES-1:0]       din,
  output logic [DEPTH*LANES-1:0] rows_flat,
  output logic [LANES-1:0]       bottom_row,
  output logic [LANES-1:0]       bottom_next
);

  logic [LANES-1:0] row_q [DEPTH];
  logic [LANES-1:0] row_d [DEPTH];

  always_comb begin
    // NOTE: every row gets a default hold value first so no path leaves a latch.
    for (int i = 0; i < DEPTH; i++) row_d[i] = row_q[i];
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) row_d[i] = '0;
    end else if (load) begin
      row_d[0] = din;
      for (int i = 1; i < DEPTH; i++) row_d[i] = row_q[i-1];
    end
  end

  // NOTE: the rows are architectural state visible on the outputs, so this
  // small array is reset like any other flop rather than left as memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) row_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every row samples its neighbour's old value.
      for (int i = 0; i < DEPTH; i++) row_q[i] <= row_d[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign rows_flat[g*LANES +: LANES] = row_q[g];
  end

  assign bottom_row = row_q[DEPTH-1];

  // With a single row, the incoming row is the loaded data itself.
  if (DEPTH > 1) begin : g_next_deep
    assign bottom_next = row_q[DEPTH-2];
  end else begin : g_next_single
    assign bottom_next = din;
  end

endmodule

// File: rtl/obstacle_scroller.sv
// ---------------------------------------------------------------------------
// obstacle_scroller
//   Game-side partner of the 3-bit LFSR lane generator. Sweeps a scroll
//   position 0..limit (driving the LFSR position input), captures one lane
//   mask per sweep into the obstacle buffer, checks the player row for a
//   collision and keeps score.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     start        : pulse, begins/restarts a game from IDLE or OVER
//     pause        : level, freezes scrolling while high
//     tick         : game-speed enable for the position counter
//     limit        : sweep end value (shared with the LFSR)
//     rand_state   : LFSR state
//     player_lane  : player lane 0..2 (3 behaves as 2)
//     position     : scroll position, to the LFSR
//     rows         : flattened obstacle rows, row i at [i*LANES +: LANES]
//     fill         : number of rows loaded, saturating at DEPTH
//     hit          : collision flag
//     score        : dodged-row count, saturating
//     run_state    : FSM state
// ---------------------------------------------------------------------------
module obstacle_scroller
  import game_pkg::*;
#(
  parameter int POS_W   = 10,
  parameter int LANES   = 3,
  parameter int DEPTH   = 4,
  parameter int SCORE_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   tick,
  input  logic [POS_W-1:0]       limit,
  input  logic [LANES-1:0]       rand_state,
  input  logic [1:0]             player_lane,
  output logic [POS_W-1:0]       position,
  output logic [DEPTH*LANES-1:0] rows,
  output logic [2:0]             fill,
  output logic                   hit,
  output logic [SCORE_W-1:0]     score,
  output logic [1:0]             run_state
);

  localparam logic [2:0] FILL_MAX = 3'(DEPTH);

  run_state_t         state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [2:0]         fill_q, fill_d;
  logic               hit_q, hit_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic               buf_clear, buf_load;
  logic [LANES-1:0]   new_mask;
  logic [LANES-1:0]   bottom_row;
  logic [LANES-1:0]   bottom_next;
  logic [1:0]         eff_lane;
  logic               wrap;
  logic               collide;

  assign new_mask = lane_mask(rand_state);
  assign eff_lane = clamp_lane(player_lane);
  // position==limit holds for exactly one cycle; that cycle is the wrap.
  assign wrap     = (pos_q == limit);
  assign collide  = bottom_next[eff_lane];

  row_shift_buffer #(
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) u_rows (
    .clk         (clk),
    .rst         (rst),
    .clear       (buf_clear),
    .load        (buf_load),
    .din         (new_mask),
    .rows_flat   (rows),
    .bottom_row  (bottom_row),
    .bottom_next (bottom_next)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    fill_d    = fill_q;
    hit_d     = hit_q;
    score_d   = score_q;
    buf_clear = 1'b0;
    buf_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pos_d = '0;
        if (start && (limit != '0)) begin
          state_d   = ST_RUN;
          fill_d    = '0;
          score_d   = '0;
          hit_d     = 1'b0;
          buf_clear = 1'b1;
        end
      end

      ST_RUN: begin
        if (wrap) begin
          // The wrap completes regardless of tick or pause.
          pos_d    = '0;
          buf_load = 1'b1;
          if (fill_q < FILL_MAX) fill_d = fill_q + 3'd1;
          if (collide) begin
            hit_d   = 1'b1;
            state_d = ST_OVER;
          end else begin
            if ((bottom_next != '0) && (score_q != '1)) score_d = score_q + SCORE_W'(1);
            if (pause) state_d = ST_PAUSED;
          end
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          // A limit lowered below the position snaps back onto it so the
          // next cycle is an ordinary wrap.
          pos_d = (pos_q < limit) ? (pos_q + POS_W'(1)) : limit;
        end
      end

      ST_PAUSED: begin
        if (!pause) state_d = ST_RUN;
      end

      ST_OVER: begin
        if (start) begin
          state_d   = ST_RUN;
          pos_d     = '0;
          fill_d    = '0;
          score_d   = '0;
          hit_d     = 1'b0;
          buf_clear = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      fill_q  <= '0;
      hit_q   <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      fill_q  <= fill_d;
      hit_q   <= hit_d;
      score_q <= score_d;
    end
  end

  assign position  = pos_q;
  assign fill      = fill_q;
  assign hit       = hit_q;
  assign score     = score_q;
  assign run_state = state_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// ---------------------------------------------------------------------------
// tb_obstacle_scroller
//   Drives obstacle_scroller with a behavioural 3-bit LFSR (steps whenever
//   position==limit at a clock edge, reset value 3'b001) and compares the
//   outputs against hand-computed vectors and sequences.
// ---------------------------------------------------------------------------
module tb_obstacle_scroller;

  localparam int POS_W   = 10;
  localparam int LANES   = 3;
  localparam int DEPTH   = 4;
  localparam int SCORE_W = 10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic                   pause;
  logic                   tick;
  logic [POS_W-1:0]       limit;
  logic [LANES-1:0]       rand_state;
  logic [1:0]             player_lane;
  logic [POS_W-1:0]       position;
  logic [DEPTH*LANES-1:0] rows;
  logic [2:0]             fill;
  logic                   hit;
  logic [SCORE_W-1:0]     score;
  logic [1:0]             run_state;

  int checks = 0;
  int errors = 0;

  logic [2:0] lfsr;
  int         lfsr_steps;

  obstacle_scroller #(
    .POS_W   (POS_W),
    .LANES   (LANES),
    .DEPTH   (DEPTH),
    .SCORE_W (SCORE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .tick        (tick),
    .limit       (limit),
    .rand_state  (rand_state),
    .player_lane (player_lane),
    .position    (position),
    .rows        (rows),
    .fill        (fill),
    .hit         (hit),
    .score       (score),
    .run_state   (run_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Partner LFSR: sequence 001,010,101,011,111,110,100,...
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= 3'b001;
      lfsr_steps <= 0;
    end else if (position == limit) begin
      lfsr       <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
      lfsr_steps <= lfsr_steps + 1;
    end
  end
  assign rand_state = lfsr;

  typedef struct {
    logic        start;
    logic        tick;
    logic [9:0]  exp_pos;
    logic [1:0]  exp_st;
    logic [2:0]  exp_fill;
    logic [11:0] exp_rows;
    int          exp_steps;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    pause = 1'b0;
    tick  = 1'b0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
  endtask

  task automatic wait_steps(input int target, input int budget);
    int n = 0;
    while ((lfsr_steps < target) && (n < budget)) begin
      step();
      n++;
    end
    check("wait_steps", lfsr_steps, target);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget);
    int n = 0;
    while ((run_state != st) && (n < budget)) begin
      step();
      n++;
    end
    check("wait_state", {30'd0, run_state}, {30'd0, st});
  endtask

  task automatic wait_pos(input logic [9:0] p, input int budget);
    int n = 0;
    while ((position != p) && (n < budget)) begin
      step();
      n++;
    end
    check("wait_pos", {22'd0, position}, {22'd0, p});
  endtask

  task automatic begin_game(input logic [1:0] lane);
    player_lane = lane;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Full game with tick every cycle until OVER, then the end-state checks.
  task automatic play(input logic [1:0] lane, input int exp_wraps,
                      input int exp_score, input logic [11:0] exp_rows);
    limit = 10'd3;
    do_reset();
    begin_game(lane);
    tick = 1'b1;
    wait_state(S_OVER, 200);
    tick = 1'b0;
    check("play_wraps", lfsr_steps, exp_wraps);
    check("play_score", {22'd0, score}, exp_score);
    check("play_hit", {31'd0, hit}, 32'd1);
    check("play_rows", {20'd0, rows}, {20'd0, exp_rows});
    check("play_pos", {22'd0, position}, 32'd0);
  endtask

  initial begin
    start = 1'b0;
    pause = 1'b0;
    tick = 1'b0;
    limit = 10'd3;
    player_lane = 2'd2;
    rst = 1'b1;
    #2;
    check("rst_pos", {22'd0, position}, 32'd0);
    check("rst_rows", {20'd0, rows}, 32'd0);
    check("rst_fill", {29'd0, fill}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_score", {22'd0, score}, 32'd0);
    check("rst_state", {30'd0, run_state}, {30'd0, S_IDLE});

    // Sweep timing: start, hold on no tick, one-cycle limit, unconditional
    // wrap, dropped tick at wrap, start ignored in RUN.
    //            start tick pos    state  fill rows     steps
    vecs[0]  = '{1'b1, 1'b0, 10'd0, S_RUN, 3'd0, 12'h000, 0};
    vecs[1]  = '{1'b0, 1'b1, 10'd1, S_RUN, 3'd0, 12'h000, 0};
    vecs[2]  = '{1'b0, 1'b0, 10'd1, S_RUN, 3'd0, 12'h000, 0};
    vecs[3]  = '{1'b0, 1'b1, 10'd2, S_RUN, 3'd0, 12'h000, 0};
    vecs[4]  = '{1'b0, 1'b1, 10'd3, S_RUN, 3'd0, 12'h000, 0};
    vecs[5]  = '{1'b0, 1'b0, 10'd0, S_RUN, 3'd1, 12'h001, 1};
    vecs[6]  = '{1'b0, 1'b1, 10'd1, S_RUN, 3'd1, 12'h001, 1};
    vecs[7]  = '{1'b0, 1'b1, 10'd2, S_RUN, 3'd1, 12'h001, 1};
    vecs[8]  = '{1'b0, 1'b1, 10'd3, S_RUN, 3'd1, 12'h001, 1};
    vecs[9]  = '{1'b0, 1'b1, 10'd0, S_RUN, 3'd2, 12'h00A, 2};
    vecs[10] = '{1'b1, 1'b1, 10'd1, S_RUN, 3'd2, 12'h00A, 2};

    #3;
    rst = 1'b0;
    step();
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].start;
      tick  = vecs[i].tick;
      step();
      check($sformatf("v%0d_pos", i), {22'd0, position}, {22'd0, vecs[i].exp_pos});
      check($sformatf("v%0d_state", i), {30'd0, run_state}, {30'd0, vecs[i].exp_st});
      check($sformatf("v%0d_fill", i), {29'd0, fill}, {29'd0, vecs[i].exp_fill});
      check($sformatf("v%0d_rows", i), {20'd0, rows}, {20'd0, vecs[i].exp_rows});
      check($sformatf("v%0d_steps", i), lfsr_steps, vecs[i].exp_steps);
    end
    start = 1'b0;
    tick  = 1'b0;

    // Collisions per lane; lane 3 behaves as lane 2.
    play(2'd0, 4, 0, 12'h2AB);
    tick = 1'b1;
    repeat (4) step();
    tick = 1'b0;
    check("over_pos_hold", {22'd0, position}, 32'd0);
    check("over_rows_hold", {20'd0, rows}, 32'h2AB);
    check("over_state_hold", {30'd0, run_state}, {30'd0, S_OVER});
    check("over_steps_hold", lfsr_steps, 4);
    play(2'd1, 5, 1, 12'h55D);
    play(2'd3, 6, 2, 12'hAEE);

    // Dodging and 111->101 substitution seen mid-game for lane 2.
    limit = 10'd3;
    do_reset();
    begin_game(2'd2);
    tick = 1'b1;
    wait_steps(5, 100);
    check("dodge_rows_w5", {20'd0, rows}, 32'h55D);
    check("dodge_score_w5", {22'd0, score}, 32'd2);
    check("dodge_fill_w5", {29'd0, fill}, 32'd4);
    check("dodge_state_w5", {30'd0, run_state}, {30'd0, S_RUN});
    wait_state(S_OVER, 100);
    check("dodge_steps_over", lfsr_steps, 6);
    check("dodge_score_over", {22'd0, score}, 32'd2);
    tick = 1'b0;

    // Pause asserted in the wrap cycle.
    do_reset();
    begin_game(2'd2);
    tick = 1'b1;
    wait_pos(10'd3, 20);
    pause = 1'b1;
    step();
    check("pause_pos", {22'd0, position}, 32'd0);
    check("pause_state", {30'd0, run_state}, {30'd0, S_PAUSED});
    check("pause_steps", lfsr_steps, 1);
    check("pause_rows", {20'd0, rows}, 32'h001);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    check("paused_pos", {22'd0, position}, 32'd0);
    check("paused_state", {30'd0, run_state}, {30'd0, S_PAUSED});
    check("paused_steps", lfsr_steps, 1);
    pause = 1'b0;
    tick  = 1'b0;
    step();
    check("resume_state", {30'd0, run_state}, {30'd0, S_RUN});
    check("resume_pos0", {22'd0, position}, 32'd0);
    tick = 1'b1;
    step();
    check("resume_pos1", {22'd0, position}, 32'd1);
    tick = 1'b0;

    // Limit lowered below the position mid-sweep.
    limit = 10'd20;
    do_reset();
    begin_game(2'd2);
    tick = 1'b1;
    wait_pos(10'd12, 40);
    limit = 10'd5;
    step();
    check("lower_pos", {22'd0, position}, 32'd5);
    check("lower_fill", {29'd0, fill}, 32'd0);
    step();
    check("lower_wrap_pos", {22'd0, position}, 32'd0);
    check("lower_wrap_fill", {29'd0, fill}, 32'd1);
    check("lower_wrap_steps", lfsr_steps, 1);
    tick = 1'b0;

    // Asynchronous reset mid-game.
    limit = 10'd3;
    do_reset();
    begin_game(2'd2);
    tick = 1'b1;
    wait_steps(5, 100);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pos", {22'd0, position}, 32'd0);
    check("arst_rows", {20'd0, rows}, 32'd0);
    check("arst_fill", {29'd0, fill}, 32'd0);
    check("arst_score", {22'd0, score}, 32'd0);
    check("arst_state", {30'd0, run_state}, {30'd0, S_IDLE});
    rst  = 1'b0;
    tick = 1'b0;

    // start with limit==0 is ignored.
    limit = 10'd0;
    begin_game(2'd2);
    check("lim0_state", {30'd0, run_state}, {30'd0, S_IDLE});
    step();
    check("lim0_pos", {22'd0, position}, 32'd0);

    // Restart from OVER clears score and rows.
    play(2'd2, 6, 2, 12'hAEE);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_state", {30'd0, run_state}, {30'd0, S_RUN});
    check("restart_score", {22'd0, score}, 32'd0);
    check("restart_rows", {20'd0, rows}, 32'd0);
    check("restart_fill", {29'd0, fill}, 32'd0);
    check("restart_hit", {31'd0, hit}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
- Game-side partner of the 3-bit LFSR lane generator.
- Drives the LFSR's `position` input and consumes its `state` output.
- Sweeps a scroll position 0..limit and captures one random lane mask per sweep into a DEPTH-row obstacle buffer.
- Checks the bottom row against the player lane; keeps score and game-over status for the display/VGA logic.

Parameters:
- POS_W, 10, width of position and limit (matches the LFSR position/limit width)
- LANES, 3, lane count; equals LFSR state width
- DEPTH, 4, obstacle rows held; row DEPTH-1 is the player row
- SCORE_W, 10, score counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins or restarts a game
- pause  in  1  level; freezes scrolling while high
- tick  in  1  one-cycle game-speed enable
- limit  in  POS_W  sweep end value; also wired to the LFSR limit input
- rand_state  in  LANES  LFSR state output
- player_lane  in  2  player lane 0..2
- position  out  POS_W  scroll position; wired to the LFSR position input
- rows  out  DEPTH*LANES  flattened buffer; row i at bits [i*3+2:i*3]; bit k set = lane k blocked
- fill  out  3  rows loaded, 0..DEPTH
- hit  out  1  collision flag
- score  out  SCORE_W  dodged-row count
- run_state  out  2  FSM state encoding

Behaviour:
- Reset values: position=0, rows=0, fill=0, hit=0, score=0, run_state=IDLE.
- Reset mid-game clears everything immediately, without waiting for a clock edge.
- FSM states: IDLE=0, RUN=1, PAUSED=2, OVER=3.
- IDLE:
  - start with limit!=0 -> RUN; position=0, rows=0, fill=0, score=0, hit=0.
  - start with limit==0 is ignored.
  - Position is held at 0. If limit==0, the LFSR free-runs; this is allowed as seed mixing.
- RUN:
  - tick with position<limit -> position+1.
  - A cycle with position==limit is a wrap cycle. Next edge is unconditional (no tick needed): position<=0 and a row shift is performed.
  - Consequence: position equals limit for exactly one clk cycle, giving exactly one LFSR step per sweep.
  - tick during a wrap cycle is dropped.
  - tick with position>limit (limit lowered mid-run) -> position<=limit; a normal wrap follows.
  - pause=1 -> PAUSED and position freezes. Exception: a wrap cycle always completes first, so PAUSED is entered with position=0.
- PAUSED:
  - pause=0 -> RUN.
  - start is ignored; tick is ignored.
- Row shift, at the wrap edge:
  - row[i]<=row[i-1] for i=1..DEPTH-1.
  - row[0]<=mask(rand_state). The mask uses the pre-step LFSR value sampled in the wrap cycle.
  - mask(s)=s, except mask(3'b111)=3'b101, so a lane is always open.
  - fill increments, saturating at DEPTH.
- Collision, evaluated on the value shifted into row[DEPTH-1] at the same edge:
  - Effective lane = player_lane, with 3 treated as 2.
  - Bit set at the effective lane -> hit<=1 and OVER at that edge; score unchanged.
  - Otherwise, if the new bottom row is nonzero -> score+1, saturating at all-ones.
  - Empty bottom rows (including fill<DEPTH start-up) score nothing.
- OVER:
  - position, rows, score and hit are held.
  - start -> RUN with the full clear as from IDLE.
- start while in RUN is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `game_pkg`:
  - FSM state typedef with the encodings above.
  - Constants ALL_BLOCKED=3'b111 and OPEN_SUB=3'b101.
  - Lane-clamp and mask functions.
- Sub-module `row_shift_buffer`:
  - DEPTH x LANES shift register with load/clear.
  - Exposes the flattened rows and the bottom row.
- The FSM, position counter, collision check and score stay in obstacle_scroller.

Test Plan:
1. Sweep timing. LFSR init=3'b001, limit=3, tick every cycle, start -> position 0,1,2,3,0, with 3 lasting one cycle. LFSR reads 010 after the first wrap and 101 after the second. rows[2:0]=001 after wrap 1.
2. Collision. Same setup, player_lane=0 -> after wrap 4, bottom row=001, hit=1, run_state=OVER, score=0. Further ticks leave position=0.
3. Dodging and mask substitution. Same setup, player_lane=2 over 8 wraps:
   - Bottom rows arrive as 001,010,101,011,101 (from 111),110,100.
   - hit rises at the 101 row: wrap 6, 2 rows dodged, score=2 (a lane-2 player collides with 101).
   - Repeat with player_lane=1: hit at row 010, wrap 5, score=1.
4. Pause at wrap. Assert pause in the cycle position==3 -> wrap still completes. Enters PAUSED with position=0 and exactly one LFSR step. Ticks in PAUSED change nothing; release resumes at 1.
5. Limit lowered mid-run. Reduce limit 20->5 at position=12, then tick -> position=5 for one cycle, then 0 with one row shift.
6. Reset and restart. rst mid-RUN -> all outputs zero, IDLE, with no clock edge needed. start with limit=0 stays IDLE. start from OVER clears score and rows and returns to RUN.
